// File: rtl/lwr_pkg.sv
// rtl/lwr_pkg.sv - shared types, default sizes and rounding helper for the LWR inner product
package lwr_pkg;

  localparam int DEF_N_LWR = 445;
  localparam int DEF_LOG_Q = 16;
  localparam int DEF_LOG_P = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } lwr_state_e;

  // Round-to-nearest from Z_q to Z_p; the half-step add wraps mod q, so acc near q maps to 0.
  function automatic logic [31:0] lwr_round(input logic [31:0] acc,
                                            input int unsigned log_q = DEF_LOG_Q,
                                            input int unsigned log_p = DEF_LOG_P);
    logic [31:0] mask;
    logic [31:0] half;
    logic [31:0] sum;
    mask = (32'd1 << log_q) - 32'd1;
    half = 32'd1 << (log_q - log_p - 1);
    sum  = (acc + half) & mask;
    return sum >> (log_q - log_p);
  endfunction

endpackage

// File: rtl/lwr_inner_product_if.sv
// rtl/lwr_inner_product_if.sv - control, key-store, coefficient and result signals of the LWR inner product
interface lwr_inner_product_if #(
  parameter int ADDR_W = 9,
  parameter int LOG_Q  = 16,
  parameter int LOG_P  = 8
);
  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] key_addr;
  logic              key_bit;
  logic [LOG_Q-1:0]  a_data;
  logic              a_valid;
  logic              a_ready;
  logic [LOG_P-1:0]  y;
  logic              y_valid;
  logic              y_ready;

  modport master (
    input  start, key_bit, a_data, a_valid, y_ready,
    output busy, key_addr, a_ready, y, y_valid
  );

  modport slave (
    output start, key_bit, a_data, a_valid, y_ready,
    input  busy, key_addr, a_ready, y, y_valid
  );
endinterface

// File: rtl/lwr_inner_product.sv
// rtl/lwr_inner_product.sv - one LWR PRF sample: y = round_p(<a, s> mod q), key read one bit per beat
module lwr_inner_product
  import lwr_pkg::*;
#(
  parameter int N_LWR = DEF_N_LWR,
  parameter int LOG_Q = DEF_LOG_Q,
  parameter int LOG_P = DEF_LOG_P
) (
  input logic               clk,
  input logic               rst,
  lwr_inner_product_if.master bus
);

  localparam int ADDR_W = $clog2(N_LWR);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_LWR - 1);

  lwr_state_e        state_q;
  lwr_state_e        state_d;
  logic [LOG_Q-1:0]  acc_q;
  logic [ADDR_W-1:0] idx_q;
  logic [LOG_P-1:0]  y_q;
  logic              y_valid_q;
  logic              beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        beat = bus.a_valid;
        if (beat && (idx_q == LAST_IDX)) state_d = ROUND;
      end
      ROUND: begin
        state_d = OUT;
      end
      OUT: begin
        if (bus.y_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // idx parks on the last element so key_addr never leaves the store's range.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      idx_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        RUN: begin
          if (beat) begin
            if (bus.key_bit) acc_q <= acc_q + bus.a_data;
            if (idx_q != LAST_IDX) idx_q <= idx_q + ADDR_W'(1);
          end
        end
        ROUND: begin
          y_q       <= LOG_P'(lwr_round(32'(acc_q), LOG_Q, LOG_P));
          y_valid_q <= 1'b1;
        end
        OUT: begin
          if (bus.y_ready) y_valid_q <= 1'b0;
        end
        default: begin
          y_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = (state_q == RUN) || (state_q == ROUND);
  assign bus.a_ready  = (state_q == RUN);
  assign bus.key_addr = idx_q;
  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;

endmodule

// File: tb/tb_lwr_inner_product.sv
// tb/tb_lwr_inner_product.sv - self-checking bench for lwr_inner_product (N=445 and N=4 instances)
module tb_lwr_inner_product;

  localparam int N = 445;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit          key_mem [0:N-1];
  logic [15:0] a_mem   [0:N-1];
  int          beat_cnt = 0;
  int          exp_y = 0;

  logic [3:0]  key4;
  logic [15:0] a4 [0:3];

  lwr_inner_product_if #(.ADDR_W(9), .LOG_Q(16), .LOG_P(8)) bus ();
  lwr_inner_product_if #(.ADDR_W(2), .LOG_Q(16), .LOG_P(8)) bus4 ();

  lwr_inner_product dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  lwr_inner_product #(.N_LWR(4), .LOG_Q(16), .LOG_P(8)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  assign bus.key_bit  = key_mem[bus.key_addr];
  assign bus4.key_bit = key4[bus4.key_addr];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain dot product over the key/vector, reduce mod 2^16, round to nearest mod 2^8.
  function automatic int model_y(input int n);
    longint sum = 0;
    for (int i = 0; i < n; i++)
      if (key_mem[i]) sum += longint'(a_mem[i]);
    sum = sum % 65536;
    return int'(((sum + 128) % 65536) / 256);
  endfunction

  task automatic load(input bit k, input logic [15:0] a);
    for (int i = 0; i < N; i++) begin
      key_mem[i] = k;
      a_mem[i]   = a;
    end
  endtask

  // Compare process: key address must track accepted beats; y must match the model while valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.a_ready) check("key_addr_tracks_beats", 64'(bus.key_addr), 64'(beat_cnt));
      if (bus.y_valid) check("y_vs_model", 64'(bus.y), 64'(exp_y));
    end
  end

  // Entered and left at a negedge; the caller's IDLE cycle is where start is driven.
  task automatic run_sample(input string name, input int vprob, input int hold_y,
                            input bit poke_start, input int lit_y, input bit chk_lat);
    int cyc;
    bit bn;
    exp_y    = model_y(N);
    beat_cnt = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check({name, "_busy_in_run"}, 64'(bus.busy), 64'd1);
    while (!bus.y_valid && cyc < 5000) begin
      bus.a_valid = ($urandom_range(1, 100) <= vprob);
      bus.a_data  = (beat_cnt < N) ? a_mem[beat_cnt] : 16'h0;
      bus.start   = poke_start && ($urandom_range(0, 7) == 0);
      bn = bus.a_valid && bus.a_ready;
      @(posedge clk);
      beat_cnt += int'(bn);
      @(negedge clk);
      cyc++;
    end
    bus.a_valid = 1'b0;
    bus.start   = 1'b0;
    if (!bus.y_valid) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (chk_lat) check({name, "_latency"}, 64'(cyc), 64'(N + 2));
    check({name, "_y"}, 64'(bus.y), 64'(lit_y));
    check({name, "_busy_in_out"}, 64'(bus.busy), 64'd0);
    for (int i = 0; i < hold_y; i++) begin
      @(negedge clk);
      check({name, "_y_valid_held"}, 64'(bus.y_valid), 64'd1);
    end
    bus.y_ready = 1'b1;
    @(negedge clk);
    bus.y_ready = 1'b0;
    check({name, "_idle_y_valid"}, 64'(bus.y_valid), 64'd0);
    check({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run4(input string name, input logic [3:0] k, input int lit_y);
    int cyc;
    int cnt;
    bit bn;
    key4 = k;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    cyc = 1;
    cnt = 0;
    while (!bus4.y_valid && cyc < 50) begin
      bus4.a_valid = 1'b1;
      bus4.a_data  = a4[(cnt < 4) ? cnt : 0];
      bn = bus4.a_ready;
      @(posedge clk);
      cnt += int'(bn);
      @(negedge clk);
      cyc++;
    end
    bus4.a_valid = 1'b0;
    check({name, "_latency"}, 64'(cyc), 64'd6);
    check({name, "_y"}, 64'(bus4.y), 64'(lit_y));
    bus4.y_ready = 1'b1;
    @(negedge clk);
    bus4.y_ready = 1'b0;
  endtask

  initial begin
    bit bn;
    bus.start = 1'b0;  bus.a_valid = 1'b0;  bus.a_data = '0;  bus.y_ready = 1'b0;
    bus4.start = 1'b0; bus4.a_valid = 1'b0; bus4.a_data = '0; bus4.y_ready = 1'b0;
    key4 = 4'b0;
    a4[0] = 16'hFF80; a4[1] = 16'd5; a4[2] = 16'd5; a4[3] = 16'd5;
    load(1'b0, 16'h0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy",     64'(bus.busy),     64'd0);
    check("reset_key_addr", 64'(bus.key_addr), 64'd0);
    check("reset_a_ready",  64'(bus.a_ready),  64'd0);
    check("reset_y",        64'(bus.y),        64'd0);
    check("reset_y_valid",  64'(bus.y_valid),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    load(1'b0, 16'hFFFF);
    check("model_pin_zero_key", 64'(model_y(N)), 64'd0);
    run_sample("zero_key", 100, 0, 1'b0, 0, 1'b1);

    load(1'b1, 16'h0001);
    check("model_pin_ones_a1", 64'(model_y(N)), 64'd2);
    run_sample("ones_a1", 100, 0, 1'b0, 2, 1'b1);

    load(1'b1, 16'hFFFF);
    check("model_pin_wrap", 64'(model_y(N)), 64'd254);
    run_sample("ones_wrap", 100, 0, 1'b0, 254, 1'b1);

    load(1'b1, 16'h0001);
    run_sample("backpressure", 50, 10, 1'b1, 2, 1'b0);

    exp_y    = model_y(N);
    beat_cnt = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.a_valid = 1'b1;
      bus.a_data  = a_mem[beat_cnt];
      bn = bus.a_ready;
      @(posedge clk);
      beat_cnt += int'(bn);
      @(negedge clk);
    end
    check("mid_key_addr_100", 64'(bus.key_addr), 64'd100);
    bus.a_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_busy",     64'(bus.busy),     64'd0);
    check("mid_reset_key_addr", 64'(bus.key_addr), 64'd0);
    check("mid_reset_a_ready",  64'(bus.a_ready),  64'd0);
    check("mid_reset_y",        64'(bus.y),        64'd0);
    check("mid_reset_y_valid",  64'(bus.y_valid),  64'd0);
    rst = 1'b0;
    beat_cnt = 0;
    @(negedge clk);
    run_sample("after_reset", 100, 0, 1'b0, 2, 1'b1);

    run4("n4_key1000", 4'b0001, 0);
    run4("n4_key1100", 4'b0011, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
